// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: prefix codes, frame FSM states and parity helper.
package ps2_pkg;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;

  // bits = {parity, data[7:0]}; PS/2 uses odd parity over all nine bits.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS/2 pins, debounces the clock line and flags its falling edges.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic ps2d_o,
  output logic fall_tick_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    c_sync_q;
  logic [1:0]    d_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      filt_q   <= 1'b1;
      cnt_q    <= '0;
      fall_q   <= 1'b0;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_i};
      d_sync_q <= {d_sync_q[0], ps2d_i};
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      fall_q   <= fall_d;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (c_sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = c_sync_q[1];
        fall_d = ~c_sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign ps2d_o      = d_sync_q[1];
  assign fall_tick_o = fall_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard frame receiver: reports make codes, drops break codes, strips E0 prefixes.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] keycodeout,
  output logic       parity_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          fall_tick;
  logic          ps2d_s;

  state_e        state_q, state_d;
  logic [3:0]    bits_q, bits_d;
  logic [8:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic [7:0]    key_q, key_d;
  logic          done_q, done_d;
  logic          perr_q, perr_d;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .ps2c_i     (ps2c),
    .ps2d_i     (ps2d),
    .ps2d_o     (ps2d_s),
    .fall_tick_o(fall_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bits_q  <= '0;
      shift_q <= '0;
      tmo_q   <= '0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      key_q   <= 8'h00;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      tmo_q   <= tmo_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      key_q   <= key_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    tmo_d   = '0;
    brk_d   = brk_q;
    ext_d   = ext_q;
    key_d   = key_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_en && fall_tick && !ps2d_s) begin
          state_d = DATA;
          bits_d  = 4'd9;
        end
      end
      DATA: begin
        if (fall_tick) begin
          shift_d = {ps2d_s, shift_q[8:1]};
          bits_d  = bits_q - 1'b1;
          if (bits_q == 4'd1) state_d = STOP;
        end
      end
      STOP: begin
        if (fall_tick) begin
          state_d = IDLE;
          bits_d  = '0;
          if (!ps2d_s || !odd_parity_ok(shift_q)) begin
            perr_d = 1'b1;
            brk_d  = 1'b0;
            ext_d  = 1'b0;
          end else if (shift_q[7:0] == CODE_BREAK) begin
            brk_d = 1'b1;
          end else if (shift_q[7:0] == CODE_EXT) begin
            ext_d = 1'b1;
          end else if (brk_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
          end else begin
            key_d  = shift_q[7:0];
            done_d = 1'b1;
            ext_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Inter-edge watchdog: an abort leaves the prefix flags untouched.
    if (state_q != IDLE && !fall_tick) begin
      if (tmo_q == TW'(TIMEOUT_CYC)) begin
        state_d = IDLE;
        bits_d  = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign rx_done_tick = done_q;
  assign keycodeout   = key_q;
  assign parity_err   = perr_q;

endmodule
